// File: rtl/lcm_cmd_rx.sv
// lcm_cmd_rx - command receiver for the local control module (LCM).
//
// Accepts 134-bit command packets and decodes the second word of each
// packet as the command:
//   opcode [127:120], register index [119:112], write data [63:0].
// A command takes effect only once the packet status strobe reports the
// packet as good. A write updates one of the sender configuration
// registers or pulses sent_start. A read raises rd_reg_n for lcm_reg_rd
// and holds it until rd_done.
//
// Optional feature: define LCM_CMD_RX_ERRCNT_EN to add the saturating
// err_cnt output, which counts protocol and command errors.
//
// Ports:
//   clk, rst_n                 clock; asynchronous active-low reset
//   in_lcm_data[133:0]         packet word: [133:132] position, [131:128] byte count, [127:0] payload
//   in_lcm_data_wr             word strobe
//   in_lcm_data_valid          packet status, 1 = good
//   in_lcm_data_valid_wr       status strobe, one per packet
//   in_lcm_data_ready          low while awaiting status or a read response
//   sent_*_o [63:0]            configuration registers, index 1-4
//   sent_start                 one-cycle pulse on a committed write to index 5
//   rd_reg_n[7:0]              requested read index, 0 = none
//   rd_done                    read response sent by lcm_reg_rd
//   err_cnt[15:0]              saturating error count (LCM_CMD_RX_ERRCNT_EN only)
module lcm_cmd_rx #(
  parameter logic [7:0] WR_ENABLE_MASK = 8'h1F
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [133:0] in_lcm_data,
  input  logic         in_lcm_data_wr,
  input  logic         in_lcm_data_valid,
  input  logic         in_lcm_data_valid_wr,
  output logic         in_lcm_data_ready,
  output logic [63:0]  sent_start_time_n_reg_o,
  output logic [63:0]  sent_rate_n_reg_o,
  output logic [63:0]  sent_time_reg_o,
  output logic [63:0]  sent_num_reg_o,
  output logic         sent_start,
  output logic [7:0]   rd_reg_n,
`ifdef LCM_CMD_RX_ERRCNT_EN
  output logic [15:0]  err_cnt,
`endif
  input  logic         rd_done
);

  localparam logic [1:0] POS_HEAD = 2'b01;
  localparam logic [1:0] POS_MID  = 2'b11;
  localparam logic [1:0] POS_TAIL = 2'b10;
  localparam logic [7:0] OP_WR    = 8'h01;
  localparam logic [7:0] OP_RD    = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_SKIP,
    S_WAIT_VLD,
    S_RD_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic        is_head, is_mid, is_tail;
  logic        latch_cmd, commit, err_evt, do_wr, do_rd;
  logic        wr_ok, rd_ok;
  logic [7:0]  op_q, idx_q, op, idx;
  logic [63:0] dat_q, dat;

  assign is_head = in_lcm_data_wr && (in_lcm_data[133:132] == POS_HEAD);
  assign is_mid  = in_lcm_data_wr && (in_lcm_data[133:132] == POS_MID);
  assign is_tail = in_lcm_data_wr && (in_lcm_data[133:132] == POS_TAIL);

  // The word after the head is the command word, whatever its position.
  assign latch_cmd = (state_q == S_CMD) && (is_mid || is_tail);

  // When the command word is also the tail and its status arrives in the
  // same cycle, the live word is decoded instead of the not-yet-latched copy.
  assign op  = latch_cmd ? in_lcm_data[127:120] : op_q;
  assign idx = latch_cmd ? in_lcm_data[119:112] : idx_q;
  assign dat = latch_cmd ? in_lcm_data[63:0]    : dat_q;

  assign wr_ok = (op == OP_WR) && (idx >= 8'd1) && (idx <= 8'd5)
                 && WR_ENABLE_MASK[idx[2:0] - 3'd1];
  assign rd_ok = (op == OP_RD) && (idx >= 8'd1) && (idx <= 8'd12);

  assign in_lcm_data_ready = !((state_q == S_WAIT_VLD) || (state_q == S_RD_WAIT));

  // Byte count and the unused middle of the command word carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{in_lcm_data[131:128], in_lcm_data[111:64]};

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    err_evt = 1'b0;
    do_wr   = 1'b0;
    do_rd   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_head)             state_d = S_CMD;
        else if (in_lcm_data_wr) err_evt = 1'b1;
        if (in_lcm_data_valid_wr) err_evt = 1'b1;
      end
      S_CMD, S_SKIP: begin
        if (is_head) begin
          // A new head abandons the packet in progress.
          state_d = S_CMD;
          err_evt = 1'b1;
        end else if (is_tail) begin
          if (in_lcm_data_valid_wr) commit = 1'b1;
          else                      state_d = S_WAIT_VLD;
        end else if (is_mid && (state_q == S_CMD)) begin
          state_d = S_SKIP;
        end
        if (in_lcm_data_valid_wr && !is_tail) err_evt = 1'b1;
      end
      S_WAIT_VLD: begin
        if (is_head) begin
          state_d = S_CMD;
          err_evt = 1'b1;
        end else if (in_lcm_data_valid_wr) begin
          commit = 1'b1;
        end
      end
      S_RD_WAIT: begin
        if (in_lcm_data_wr) err_evt = 1'b1;
        if (rd_done)        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      state_d = S_IDLE;
      if (!in_lcm_data_valid) begin
        err_evt = 1'b1;
      end else if (wr_ok) begin
        do_wr = 1'b1;
      end else if (rd_ok) begin
        do_rd   = 1'b1;
        state_d = S_RD_WAIT;
      end else begin
        err_evt = 1'b1;
      end
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so all
  // registers sample the same pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      idx_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      if (latch_cmd) begin
        op_q  <= in_lcm_data[127:120];
        idx_q <= in_lcm_data[119:112];
        dat_q <= in_lcm_data[63:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sent_start_time_n_reg_o <= '0;
      sent_rate_n_reg_o       <= '0;
      sent_time_reg_o         <= '0;
      sent_num_reg_o          <= '0;
      sent_start              <= 1'b0;
      rd_reg_n                <= '0;
    end else begin
      sent_start <= do_wr && (idx == 8'd5);
      if (do_wr) begin
        case (idx)
          8'd1:    sent_start_time_n_reg_o <= dat;
          8'd2:    sent_rate_n_reg_o       <= dat;
          8'd3:    sent_time_reg_o         <= dat;
          8'd4:    sent_num_reg_o          <= dat;
          default: ;
        endcase
      end
      if (do_rd)                                   rd_reg_n <= idx;
      else if ((state_q == S_RD_WAIT) && rd_done)  rd_reg_n <= '0;
    end
  end

`ifdef LCM_CMD_RX_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                err_cnt <= '0;
    else if (err_evt && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
  end
`else
  logic unused_err;
  assign unused_err = err_evt;
`endif

endmodule

// File: tb/tb_lcm_cmd_rx.sv
// tb_lcm_cmd_rx - self-checking bench for lcm_cmd_rx.
// A packet-level model holds the expected outputs; a compare process checks
// every output against it on each falling clock edge, and directed steps add
// literal expectations for key results.
module tb_lcm_cmd_rx;

  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] MID  = 2'b11;
  localparam logic [1:0] TAIL = 2'b10;
  localparam logic [7:0] WR_MASK = 8'h1F;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [133:0] in_lcm_data;
  logic         in_lcm_data_wr, in_lcm_data_valid, in_lcm_data_valid_wr;
  logic         in_lcm_data_ready;
  logic [63:0]  sent_start_time_n_reg_o, sent_rate_n_reg_o, sent_time_reg_o, sent_num_reg_o;
  logic         sent_start;
  logic [7:0]   rd_reg_n;
  logic         rd_done;
`ifdef LCM_CMD_RX_ERRCNT_EN
  logic [15:0]  err_cnt;
`endif

  always #5 clk = ~clk;

  lcm_cmd_rx #(.WR_ENABLE_MASK(WR_MASK)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .in_lcm_data             (in_lcm_data),
    .in_lcm_data_wr          (in_lcm_data_wr),
    .in_lcm_data_valid       (in_lcm_data_valid),
    .in_lcm_data_valid_wr    (in_lcm_data_valid_wr),
    .in_lcm_data_ready       (in_lcm_data_ready),
    .sent_start_time_n_reg_o (sent_start_time_n_reg_o),
    .sent_rate_n_reg_o       (sent_rate_n_reg_o),
    .sent_time_reg_o         (sent_time_reg_o),
    .sent_num_reg_o          (sent_num_reg_o),
    .sent_start              (sent_start),
    .rd_reg_n                (rd_reg_n),
`ifdef LCM_CMD_RX_ERRCNT_EN
    .err_cnt                 (err_cnt),
`endif
    .rd_done                 (rd_done)
  );

  // ---------------- model ----------------
  logic [63:0] exp_reg [1:4];
  logic        exp_start, exp_ready;
  logic [7:0]  exp_rd;
  logic [15:0] exp_err;
  int          n_pass = 0;
  int          n_checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    for (int i = 1; i <= 4; i++) exp_reg[i] = 64'd0;
    exp_start = 1'b0;
    exp_ready = 1'b1;
    exp_rd    = 8'd0;
    exp_err   = 16'd0;
  endfunction

  function automatic void model_err();
    if (exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
  endfunction

  // Outcome of a packet whose status has just been delivered.
  function automatic void model_commit(input logic [7:0] op, input logic [7:0] idx,
                                       input logic [63:0] d, input logic good);
    logic [7:0] m;
    int k;
    m = WR_MASK;
    k = int'(idx);
    exp_ready = 1'b1;
    if (!good) model_err();
    else if (op == 8'h01 && k >= 1 && k <= 5 && m[k-1]) begin
      if (k == 5) exp_start = 1'b1;
      else        exp_reg[k] = d;
    end else if (op == 8'h02 && k >= 1 && k <= 12) begin
      exp_rd    = idx;
      exp_ready = 1'b0;
    end else model_err();
  endfunction

  function automatic void model_done();
    if (exp_rd != 8'd0) begin
      exp_rd    = 8'd0;
      exp_ready = 1'b1;
    end
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    check("ready",      64'(in_lcm_data_ready), 64'(exp_ready));
    check("start_time", sent_start_time_n_reg_o, exp_reg[1]);
    check("rate",       sent_rate_n_reg_o,       exp_reg[2]);
    check("time",       sent_time_reg_o,         exp_reg[3]);
    check("num",        sent_num_reg_o,          exp_reg[4]);
    check("sent_start", 64'(sent_start),         64'(exp_start));
    check("rd_reg_n",   64'(rd_reg_n),           64'(exp_rd));
`ifdef LCM_CMD_RX_ERRCNT_EN
    check("err_cnt",    64'(err_cnt),            64'(exp_err));
`endif
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [1:0] pos, input logic [127:0] pl, input logic wr,
                      input logic vwr, input logic vld, input logic done);
    in_lcm_data          = {pos, 4'h0, pl};
    in_lcm_data_wr       = wr;
    in_lcm_data_valid_wr = vwr;
    in_lcm_data_valid    = vld;
    rd_done              = done;
    @(posedge clk);
    #1;
    in_lcm_data_wr       = 1'b0;
    in_lcm_data_valid_wr = 1'b0;
    in_lcm_data_valid    = 1'b0;
    rd_done              = 1'b0;
    exp_start            = 1'b0;
  endtask

  task automatic idle();
    step(2'b00, 128'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [127:0] cmd_word(input logic [7:0] op, input logic [7:0] idx,
                                            input logic [63:0] d);
    return {op, idx, 48'h0, d};
  endfunction

  // Full packet: head, command word, n_mid-1 filler words, tail (command
  // word is the tail when n_mid == 0). head_err marks a head that restarts
  // an abandoned packet.
  task automatic send_pkt(input logic [7:0] op, input logic [7:0] idx, input logic [63:0] d,
                          input logic good, input int n_mid, input logic coincident,
                          input logic head_err);
    step(HEAD, 128'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    if (head_err) model_err();
    if (n_mid == 0) begin
      step(TAIL, cmd_word(op, idx, d), 1'b1, coincident, good, 1'b0);
    end else begin
      step(MID, cmd_word(op, idx, d), 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i < n_mid; i++) step(MID, {4{32'hDEAD_BEEF}}, 1'b1, 1'b0, 1'b0, 1'b0);
      step(TAIL, {4{32'hFFFF_FFFF}}, 1'b1, coincident, good, 1'b0);
    end
    if (!coincident) begin
      exp_ready = 1'b0;
      idle();
      step(2'b00, 128'd0, 1'b0, 1'b1, good, 1'b0);
    end
    model_commit(op, idx, d, good);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    model_reset();
    in_lcm_data = '0;
    in_lcm_data_wr = 1'b0;
    in_lcm_data_valid = 1'b0;
    in_lcm_data_valid_wr = 1'b0;
    rd_done = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("pin_rst_ready", 64'(in_lcm_data_ready), 64'd1);
    check("pin_rst_rd", 64'(rd_reg_n), 64'd0);

    // Write start time.
    send_pkt(8'h01, 8'h01, 64'h1234, 1'b1, 1, 1'b0, 1'b0);
    check("pin_wr_start_time", sent_start_time_n_reg_o, 64'h1234);
    check("pin_wr_rate_zero", sent_rate_n_reg_o, 64'd0);

    // Read with handshake; stray rd_done afterwards is ignored.
    send_pkt(8'h02, 8'h03, 64'd0, 1'b1, 1, 1'b0, 1'b0);
    repeat (3) idle();
    check("pin_rd_idx", 64'(rd_reg_n), 64'd3);
    check("pin_rd_ready", 64'(in_lcm_data_ready), 64'd0);
    step(2'b00, 128'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    model_done();
    check("pin_rd_clear", 64'(rd_reg_n), 64'd0);
    check("pin_rd_ready_back", 64'(in_lcm_data_ready), 64'd1);
    step(2'b00, 128'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    model_done();

    // Bad packet.
    send_pkt(8'h01, 8'h02, 64'd99, 1'b0, 1, 1'b0, 1'b0);
    check("pin_bad_rate", sent_rate_n_reg_o, 64'd0);
`ifdef LCM_CMD_RX_ERRCNT_EN
    check("pin_bad_err", 64'(err_cnt), 64'd1);
`endif

    // Unknown opcode, out-of-range write, then start pulse.
    send_pkt(8'h07, 8'h01, 64'd55, 1'b1, 1, 1'b0, 1'b0);
    send_pkt(8'h01, 8'h09, 64'd77, 1'b1, 0, 1'b0, 1'b0);
`ifdef LCM_CMD_RX_ERRCNT_EN
    check("pin_unk_err", 64'(err_cnt), 64'd3);
`endif
    check("pin_unk_start_time", sent_start_time_n_reg_o, 64'h1234);
    send_pkt(8'h01, 8'h05, 64'd0, 1'b1, 1, 1'b0, 1'b0);
    check("pin_start_pulse", 64'(sent_start), 64'd1);
    idle();
    check("pin_start_gone", 64'(sent_start), 64'd0);

    // Truncated packets, then status coincident with the tail.
    step(HEAD, 128'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_pkt(8'h01, 8'h04, 64'd5, 1'b1, 1, 1'b0, 1'b1);
    check("pin_trunc_num", sent_num_reg_o, 64'd5);
    step(HEAD, 128'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_pkt(8'h01, 8'h04, 64'd7, 1'b1, 2, 1'b1, 1'b1);
    check("pin_coinc_skip_num", sent_num_reg_o, 64'd7);
    send_pkt(8'h01, 8'h03, 64'hABCD, 1'b1, 0, 1'b1, 1'b0);
    check("pin_coinc_cmd_time", sent_time_reg_o, 64'hABCD);

    // Stray tail and stray status in IDLE.
    step(TAIL, cmd_word(8'h01, 8'h01, 64'hEEEE), 1'b1, 1'b0, 1'b0, 1'b0);
    model_err();
    step(2'b00, 128'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    model_err();
    check("pin_stray_start_time", sent_start_time_n_reg_o, 64'h1234);

    // Read index 12 with a word dropped while waiting.
    send_pkt(8'h02, 8'h0C, 64'd0, 1'b1, 0, 1'b0, 1'b0);
    step(HEAD, 128'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    model_err();
    idle();
    step(2'b00, 128'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    model_done();

    // Head while awaiting status restarts the packet.
    step(HEAD, 128'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(TAIL, cmd_word(8'h01, 8'h02, 64'h55), 1'b1, 1'b0, 1'b0, 1'b0);
    exp_ready = 1'b0;
    step(HEAD, 128'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    model_err();
    exp_ready = 1'b1;
    step(TAIL, cmd_word(8'h01, 8'h02, 64'h66), 1'b1, 1'b0, 1'b0, 1'b0);
    exp_ready = 1'b0;
    step(2'b00, 128'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    model_commit(8'h01, 8'h02, 64'h66, 1'b1);
    check("pin_restart_rate", sent_rate_n_reg_o, 64'h66);

    // Out-of-range read and write to index 0.
    send_pkt(8'h02, 8'h0D, 64'd0, 1'b1, 1, 1'b0, 1'b0);
    send_pkt(8'h01, 8'h00, 64'd1, 1'b1, 1, 1'b0, 1'b0);

    // Reset mid-packet after the command word.
    step(HEAD, 128'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(MID, cmd_word(8'h01, 8'h02, 64'hBAD), 1'b1, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("pin_async_rate", sent_rate_n_reg_o, 64'd0);
    check("pin_async_num", sent_num_reg_o, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(TAIL, {4{32'h1111_1111}}, 1'b1, 1'b0, 1'b0, 1'b0);
    model_err();
    step(2'b00, 128'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    model_err();
    check("pin_rst_nocommit", sent_rate_n_reg_o, 64'd0);
    send_pkt(8'h01, 8'h02, 64'hC0DE, 1'b1, 1, 1'b0, 1'b0);
    check("pin_post_rst_rate", sent_rate_n_reg_o, 64'hC0DE);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
